exec_completion_buffer: RTL
===========================

// Module: exec_completion_buffer
// PURPOSE
//  In-order completion buffer between ExecuteStage issue and MemoryAccess/RegWrite retire.
//  Lets up to DEPTH ops be in flight across NUM_UNITS out-of-order-completing units (MulDiv, Fp32, Fp64, LSU).
//  The execute stage no longer stalls on multi-cycle units.
//  Retires results, fflags and traps strictly in program order; flags RAW hazards on in-flight destination registers.
// PARAMETERS
//  XLEN       32  integer result width
//  FLEN       64  FP result width
//  DEPTH      4   entries; power of two, >=2
//  NUM_UNITS  4   completion ports
//  IDX_W      $clog2(DEPTH)  entry index width (derived)
//  TAG_W      IDX_W+1        {epoch, index} (derived)
// PORTS
//  clk            in   1                 clock
//  rst            in   1                 synchronous, active-high reset
//  flush          in   1                 discard all entries (branch/trap redirect)
//  issue_valid    in   1                 execute stage offers op
//  issue_ready    out  1                 count<DEPTH && !flush
//  issue_pc       in   XLEN              op pc
//  issue_rd       in   5                 destination register
//  issue_int_we   in   1                 writes int rd
//  issue_fp_we    in   1                 writes fp rd
//  issue_tag      out  TAG_W             tag for the allocated entry, valid with handshake
//  cmpl_valid     in   NUM_UNITS         per-unit completion strobe
//  cmpl_tag       in   NUM_UNITS*TAG_W   per-unit tag
//  cmpl_int_value in   NUM_UNITS*XLEN    per-unit int result
//  cmpl_fp_value  in   NUM_UNITS*FLEN    per-unit fp result
//  cmpl_fflags    in   NUM_UNITS*5       per-unit fflags
//  cmpl_trap      in   NUM_UNITS         per-unit exception
//  ret_valid      out  1                 head entry done
//  ret_ready      in   1                 consumer accepts head
//  ret_pc/ret_rd/ret_int_we/ret_fp_we  out  XLEN/5/1/1   head entry fields
//  ret_int_value  out  XLEN              head int result
//  ret_fp_value   out  FLEN              head fp result
//  ret_fflags     out  5                 head fflags
//  ret_trap       out  1                 head fflags/trap
//  hz_rs1,hz_rs2  in   5                 int source query
//  hz_busy1,hz_busy2 out 1               in-flight int writer to rsN exists (rsN!=0)
//  count          out  IDX_W+1           occupancy
// BEHAVIOUR
//  Reset: all entries invalid; head=tail=0, count=0, epoch=0; ret_valid=0, issue_ready=1, hz_busy*=0.
//  Issue: on issue_valid&&issue_ready, entry[tail] <= {valid=1, done=0, fields}; issue_tag={epoch,tail}; tail++ (wraps mod DEPTH).
//  issue_ready uses registered count only; a full buffer does not accept issue in a cycle that retires.
//  Completion: a port with cmpl_valid, tag epoch==epoch and entry[idx].valid&&!done latches value/fflags/trap and sets done.
//  Stale epoch, invalid entry or already-done entry: completion dropped silently (sim assertion fires on non-stale cases).
//  Two ports, same tag, same cycle: lowest port index wins; distinct tags all accepted the same cycle.
//  Retire: ret_* driven combinationally from registered entry[head]; ret_valid = entry[head].valid && done.
//  Latency: completion at cycle N -> ret_valid at N+1 at the earliest.
//  On ret_valid&&ret_ready: entry[head].valid<=0, head++.
//  Trap retire: ret_trap=1 accepted -> all younger entries invalidated, head=tail, count=0, epoch toggles, all next cycle.
//  flush: same clearing as a trap retire, next cycle; issue, completion and retire in the flush cycle are ignored (ret_valid forced 0).
//  count next = count + issue_fire - ret_fire; simultaneous issue+retire keeps count.
//  Hazard: hz_busyN = OR over valid entries with int_we && rd==hz_rsN && hz_rsN!=0, done or not.
//  Hazard is combinational from registered state.
//  rst asserted mid-operation: same as the reset state next cycle; epoch resets to 0.
// STRUCTURE
//  Package RafiTypes gains: typedef cb_tag_t, struct CompletionEntry {valid, done, trap, pc, rd, int_we, fp_we, int_value, fp_value, fflags}.
//  Sub-module exec_cb_hazard_match: DEPTH-wide rd comparator, two query ports; instantiated once.
//  Everything else (pointers, epoch, entry array) stays flat in this module.
// TESTING
//  Issue A(rd=5), complete A value 0x11 -> ret_valid next cycle, ret_rd=5, ret_int_value=0x11; count 1->0.
//  Issue A,B,C; complete C then B then A -> retire order A,B,C; ret_valid low until A done.
//  Fill 4 entries -> issue_ready=0; retire 1 with issue_valid high -> no issue that cycle, issue_ready=1 next cycle.
//  Issue A,B; flush; old-epoch completion for B -> dropped; new issue gets tag epoch=1, index=2; count=1.
//  A completes with cmpl_trap=1, B done -> retire A with ret_trap=1; next cycle count=0 and B is never retired.
//  In-flight int_we rd=7: hz_rs1=7 -> hz_busy1=1; hz_rs2=0 with rd=0 -> hz_busy2=0; after retire -> 0.

Source files
------------

// File: rtl/exec_completion_buffer_pkg.sv
// Shared types and sizing for the in-order execute completion buffer.
//   CB_XLEN / CB_FLEN      : integer / floating-point result widths
//   CB_DEPTH               : number of in-flight entries (power of two, >= 2)
//   CB_NUM_UNITS           : number of completion ports
//   cb_tag_t               : {epoch, index} handed out at issue, returned on completion
//   completion_entry_t     : one buffer slot
package exec_completion_buffer_pkg;

    localparam int CB_XLEN      = 32;
    localparam int CB_FLEN      = 64;
    localparam int CB_DEPTH     = 4;
    localparam int CB_NUM_UNITS = 4;
    localparam int CB_IDX_W     = $clog2(CB_DEPTH);
    localparam int CB_TAG_W     = CB_IDX_W + 1;
    localparam int CB_PORT_W    = (CB_NUM_UNITS > 1) ? $clog2(CB_NUM_UNITS) : 1;

    typedef logic [CB_TAG_W-1:0] cb_tag_t;

    typedef struct packed {
        logic                valid;
        logic                done;
        logic                trap;
        logic [CB_XLEN-1:0]  pc;
        logic [4:0]          rd;
        logic                int_we;
        logic                fp_we;
        logic [CB_XLEN-1:0]  int_value;
        logic [CB_FLEN-1:0]  fp_value;
        logic [4:0]          fflags;
    } completion_entry_t;

    // The epoch bit sits above the index so stale completions from before a
    // flush/trap can be told apart from live ones that reuse the same slot.
    function automatic cb_tag_t make_tag(input logic epoch, input logic [CB_IDX_W-1:0] idx);
        return {epoch, idx};
    endfunction

endpackage

// File: rtl/exec_cb_hazard_match.sv
// RAW hazard lookup over all buffer entries.
//   valid, int_we : per-entry occupancy and integer-write flags
//   rd            : per-entry destination register, 5 bits per entry
//   rs1, rs2      : integer source registers being queried
//   busy1, busy2  : an in-flight integer writer of rsN exists (never for x0)
module exec_cb_hazard_match #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]   valid,
    input  logic [DEPTH-1:0]   int_we,
    input  logic [DEPTH*5-1:0] rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    output logic               busy1,
    output logic               busy2
);

    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign match1[gi] = valid[gi] && int_we[gi] && (rd[gi*5 +: 5] == rs1);
            assign match2[gi] = valid[gi] && int_we[gi] && (rd[gi*5 +: 5] == rs2);
        end
    endgenerate

    // x0 is hard-wired zero, so a pending write to it never blocks a reader.
    assign busy1 = (rs1 != 5'd0) && (|match1);
    assign busy2 = (rs2 != 5'd0) && (|match2);

endmodule

// File: rtl/exec_completion_buffer.sv
// In-order completion buffer between execute issue and retire.
// Ops are allocated in program order at issue, completed out of order by the
// functional units (addressed by tag), and retired strictly from the head.
//   clk, rst              : clock, synchronous active-high reset
//   flush                 : discard every entry (redirect)
//   issue_*               : allocation handshake; issue_tag names the new slot
//   cmpl_*                : NUM_UNITS completion ports, packed per port
//   ret_*                 : head entry, valid once its result has arrived
//   hz_rs1/2, hz_busy1/2  : RAW query against in-flight integer writers
//   count                 : current occupancy
module exec_completion_buffer
    import exec_completion_buffer_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          issue_valid,
    output logic                          issue_ready,
    input  logic [CB_XLEN-1:0]            issue_pc,
    input  logic [4:0]                    issue_rd,
    input  logic                          issue_int_we,
    input  logic                          issue_fp_we,
    output logic [CB_TAG_W-1:0]           issue_tag,
    input  logic [CB_NUM_UNITS-1:0]       cmpl_valid,
    input  logic [CB_NUM_UNITS*CB_TAG_W-1:0] cmpl_tag,
    input  logic [CB_NUM_UNITS*CB_XLEN-1:0]  cmpl_int_value,
    input  logic [CB_NUM_UNITS*CB_FLEN-1:0]  cmpl_fp_value,
    input  logic [CB_NUM_UNITS*5-1:0]     cmpl_fflags,
    input  logic [CB_NUM_UNITS-1:0]       cmpl_trap,
    output logic                          ret_valid,
    input  logic                          ret_ready,
    output logic [CB_XLEN-1:0]            ret_pc,
    output logic [4:0]                    ret_rd,
    output logic                          ret_int_we,
    output logic                          ret_fp_we,
    output logic [CB_XLEN-1:0]            ret_int_value,
    output logic [CB_FLEN-1:0]            ret_fp_value,
    output logic [4:0]                    ret_fflags,
    output logic                          ret_trap,
    input  logic [4:0]                    hz_rs1,
    input  logic [4:0]                    hz_rs2,
    output logic                          hz_busy1,
    output logic                          hz_busy2,
    output logic [CB_IDX_W:0]             count
);

    localparam logic [CB_IDX_W:0] FULL_COUNT = (CB_IDX_W+1)'(CB_DEPTH);

    completion_entry_t        entry_reg [CB_DEPTH];
    logic [CB_IDX_W-1:0]      head_reg;
    logic [CB_IDX_W-1:0]      tail_reg;
    logic [CB_IDX_W-1:0]      tail_next;
    logic [CB_IDX_W:0]        count_reg;
    logic [CB_IDX_W:0]        count_next;
    logic                     epoch_reg;

    completion_entry_t        head_entry;
    logic                     issue_fire;
    logic                     ret_fire;
    logic                     clear_all;

    logic [CB_IDX_W-1:0]      cmpl_idx [CB_NUM_UNITS];
    logic [CB_NUM_UNITS-1:0]  cmpl_cur;
    logic [CB_DEPTH-1:0]      cmpl_hit;
    logic [CB_PORT_W-1:0]     cmpl_sel [CB_DEPTH];

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign head_entry  = entry_reg[head_reg];

    // Occupancy is taken from the register only, so a full buffer does not
    // accept a new op even in the cycle its head retires.
    assign issue_ready = (count_reg != FULL_COUNT) && !flush;
    assign issue_fire  = issue_valid && issue_ready;
    assign issue_tag   = make_tag(epoch_reg, tail_reg);

    assign ret_valid   = head_entry.valid && head_entry.done && !flush;
    assign ret_fire    = ret_valid && ret_ready;
    assign clear_all   = flush || (ret_fire && head_entry.trap);

    assign ret_pc        = head_entry.pc;
    assign ret_rd        = head_entry.rd;
    assign ret_int_we    = head_entry.int_we;
    assign ret_fp_we     = head_entry.fp_we;
    assign ret_int_value = head_entry.int_value;
    assign ret_fp_value  = head_entry.fp_value;
    assign ret_fflags    = head_entry.fflags;
    assign ret_trap      = head_entry.trap;

    assign tail_next  = issue_fire ? tail_reg + 1'b1 : tail_reg;
    assign count_next = count_reg + {{CB_IDX_W{1'b0}}, issue_fire}
                                  - {{CB_IDX_W{1'b0}}, ret_fire};
    assign count      = count_reg;

    // ------------------------------------------------------------------
    // Completion routing
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < CB_NUM_UNITS; gi++) begin : g_port
            assign cmpl_idx[gi] = cmpl_tag[gi*CB_TAG_W +: CB_IDX_W];
            // Only tags from the current epoch can address a live entry.
            assign cmpl_cur[gi] = cmpl_valid[gi]
                               && (cmpl_tag[gi*CB_TAG_W + CB_IDX_W] == epoch_reg);
        end
    endgenerate

    // Scan ports high to low so the lowest-numbered port claiming a slot wins.
    always_comb begin
        for (int e = 0; e < CB_DEPTH; e++) begin
            cmpl_hit[e] = 1'b0;
            cmpl_sel[e] = '0;
            for (int p = CB_NUM_UNITS - 1; p >= 0; p--) begin
                if (cmpl_cur[p] && (cmpl_idx[p] == CB_IDX_W'(e))) begin
                    cmpl_hit[e] = 1'b1;
                    cmpl_sel[e] = CB_PORT_W'(p);
                end
            end
            // Results for empty or already-finished slots are dropped.
            cmpl_hit[e] = cmpl_hit[e] && entry_reg[e].valid && !entry_reg[e].done;
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            epoch_reg <= 1'b0;
            for (int e = 0; e < CB_DEPTH; e++) begin
                entry_reg[e] <= '0;
            end
        end else if (clear_all) begin
            // Everything in flight is younger than the redirect; drop it all
            // and bump the epoch so its late completions are recognised as stale.
            for (int e = 0; e < CB_DEPTH; e++) begin
                entry_reg[e].valid <= 1'b0;
                entry_reg[e].done  <= 1'b0;
            end
            head_reg  <= tail_next;
            tail_reg  <= tail_next;
            count_reg <= '0;
            epoch_reg <= ~epoch_reg;
        end else begin
            for (int e = 0; e < CB_DEPTH; e++) begin
                if (issue_fire && (tail_reg == CB_IDX_W'(e))) begin
                    entry_reg[e].valid     <= 1'b1;
                    entry_reg[e].done      <= 1'b0;
                    entry_reg[e].trap      <= 1'b0;
                    entry_reg[e].pc        <= issue_pc;
                    entry_reg[e].rd        <= issue_rd;
                    entry_reg[e].int_we    <= issue_int_we;
                    entry_reg[e].fp_we     <= issue_fp_we;
                    entry_reg[e].int_value <= '0;
                    entry_reg[e].fp_value  <= '0;
                    entry_reg[e].fflags    <= '0;
                end else if (ret_fire && (head_reg == CB_IDX_W'(e))) begin
                    entry_reg[e].valid <= 1'b0;
                end else if (cmpl_hit[e]) begin
                    entry_reg[e].done      <= 1'b1;
                    entry_reg[e].trap      <= cmpl_trap[cmpl_sel[e]];
                    entry_reg[e].int_value <= cmpl_int_value[int'(cmpl_sel[e])*CB_XLEN +: CB_XLEN];
                    entry_reg[e].fp_value  <= cmpl_fp_value[int'(cmpl_sel[e])*CB_FLEN +: CB_FLEN];
                    entry_reg[e].fflags    <= cmpl_fflags[int'(cmpl_sel[e])*5 +: 5];
                end
            end
            head_reg  <= ret_fire ? head_reg + 1'b1 : head_reg;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // A current-epoch completion must target a live, unfinished slot; anything
    // else means a unit reported twice or reported for an op it never received.
    always @(posedge clk) begin
        if (!rst && !flush) begin
            for (int p = 0; p < CB_NUM_UNITS; p++) begin
                if (cmpl_cur[p]) begin
                    assert (entry_reg[cmpl_idx[p]].valid && !entry_reg[cmpl_idx[p]].done);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Hazard lookup
    // ------------------------------------------------------------------
    logic [CB_DEPTH-1:0]   hz_valid;
    logic [CB_DEPTH-1:0]   hz_int_we;
    logic [CB_DEPTH*5-1:0] hz_rd;

    generate
        for (genvar gi = 0; gi < CB_DEPTH; gi++) begin : g_hz
            assign hz_valid[gi]       = entry_reg[gi].valid;
            assign hz_int_we[gi]      = entry_reg[gi].int_we;
            assign hz_rd[gi*5 +: 5]   = entry_reg[gi].rd;
        end
    endgenerate

    exec_cb_hazard_match #(
        .DEPTH (CB_DEPTH)
    ) u_hazard (
        .valid  (hz_valid),
        .int_we (hz_int_we),
        .rd     (hz_rd),
        .rs1    (hz_rs1),
        .rs2    (hz_rs2),
        .busy1  (hz_busy1),
        .busy2  (hz_busy2)
    );

endmodule
